// File: rtl/cla_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// cla_seq_ctrl_if -- handshake bundle for the sequential CLA adder.
//
// Request side : in_valid / in_ready, operands in_a / in_b, in_cin, in_sub
// Result side  : out_valid / out_ready, out_sum, out_cout, out_ovf
// Status       : busy (high whenever the block is not idle)
//
// slave  : view taken by cla_seq_ctrl
// master : view taken by the requester / consumer
// ---------------------------------------------------------------------------
interface cla_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/cla_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cla_seq_ctrl -- WIDTH-bit add/subtract built from one 4-bit carry-look-ahead
// slice reused over NIB = WIDTH/4 consecutive cycles, least significant
// nibble first.
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cla_seq_ctrl_if.slave
//           in_valid/in_ready handshake accepts {in_a, in_b, in_cin, in_sub}
//           out_valid/out_ready handshake returns {out_sum, out_cout, out_ovf}
//           busy is high in RUN and DONE
//
// An operation is accepted in IDLE, walks through RUN for NIB cycles and then
// holds its result in DONE until the consumer takes it.
// ---------------------------------------------------------------------------
module cla_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_seq_ctrl_if.slave   bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [WIDTH-1:0] op_a_q,  op_a_d;
    logic [WIDTH-1:0] op_b_q,  op_b_d;   // already inverted for subtract
    logic             c_q,     c_d;      // carry between slices
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    // -----------------------------------------------------------------------
    // 4-bit CLA slice: every carry is a flat sum-of-products of P, G and the
    // slice carry-in, so there is no ripple inside the slice.
    // -----------------------------------------------------------------------
    logic [IDX_W+1:0] base;
    logic [3:0]       nib_a, nib_b, p, g, slice_sum;
    logic             c0, c1, c2, c3, c4;

    always_comb begin
        base  = {idx_q, 2'b00};
        nib_a = op_a_q[base +: 4];
        nib_b = op_b_q[base +: 4];
        p     = nib_a ^ nib_b;
        g     = nib_a & nib_b;
        c0    = c_q;
        c1    = g[0] | (p[0] & c0);
        c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
        c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        slice_sum = p ^ {c3, c2, c1, c0};
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d takes its _q value first so no path through the case
        // leaves a variable unassigned, which would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_a_d  = bus.in_a;
                    op_b_d  = bus.in_sub ? ~bus.in_b : bus.in_b;
                    // Subtract is A + ~B + 1, so the forced carry replaces in_cin.
                    c_d     = bus.in_sub ? 1'b1 : bus.in_cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: 4] = slice_sum;
                c_d              = c4;
                idx_d            = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = c4;
                    ovf_d   = c3 ^ c4;   // carry into MSB vs carry out of MSB
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE here (not accepting) keeps the output
                // handshake and a new acceptance in separate cycles.
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from flops; out_sum shows the partial sum in RUN.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_ctrl -- self-checking bench for cla_seq_ctrl, WIDTH = 16.
// Directed vector table plus hand-written sequences for backpressure,
// mid-operation reset and a back-to-back stream checked against a model.
// ---------------------------------------------------------------------------
module tb_cla_seq_ctrl;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cla_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    // Independent reference: full-width arithmetic, overflow from sign bits.
    function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic cin, input logic sub);
        logic [15:0] beff;
        logic [16:0] full;
        logic        ovf;
        beff = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, beff} + {16'd0, (sub ? 1'b1 : cin)};
        ovf  = (a[15] == beff[15]) && (full[15] != a[15]);
        return {ovf, full};
    endfunction

    // One complete operation: accept, count latency, collect result, release.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          output logic [15:0] s, output logic co, output logic ov,
                          output int lat);
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        check("ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs: the operation in flight must not see them.
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_cin   = ~cin;
        bus.in_sub   = ~sub;
        check("busy_ready_valid_after_accept",
              {29'd0, bus.busy, bus.in_ready, bus.out_valid}, 32'b100);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s  = bus.out_sum;
        co = bus.out_cout;
        ov = bus.out_ovf;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_after_out_handshake",
              {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
    endtask

    initial begin
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        int          wait_cyc;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[9] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;

        // ---- reset state, checked before any clock edge ----
        #2;
        check("reset_outputs",
              {13'd0, bus.out_sum, bus.out_valid, bus.out_cout, bus.out_ovf, bus.busy, bus.in_ready},
              32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- directed vector table ----
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, co, ov, lat);
            check($sformatf("vec%0d_sum", i),     {16'd0, s},  {16'd0, vecs[i].sum});
            check($sformatf("vec%0d_cout", i),    {31'd0, co}, {31'd0, vecs[i].cout});
            check($sformatf("vec%0d_ovf", i),     {31'd0, ov}, {31'd0, vecs[i].ovf});
            check($sformatf("vec%0d_latency", i), lat,         32'd4);
        end

        // ---- backpressure: result held for 10 cycles, in_valid ignored ----
        @(negedge clk);
        bus.in_a = 16'h1234; bus.in_b = 16'h1111; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_cyc = 0;
        while (!bus.out_valid && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("bp_reached_done", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_a     = 16'($urandom);
            bus.in_b     = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_hold%0d", i),
                  {13'd0, bus.out_sum, bus.out_valid, bus.out_cout, bus.in_ready},
                  {13'd0, 16'h2345, 1'b1, 1'b0, 1'b0});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_idle", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);

        // ---- asynchronous reset in the middle of RUN (idx = 2) ----
        @(negedge clk);
        bus.in_a = 16'h1234; bus.in_b = 16'h1111; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("partial_sum_before_reset", {16'd0, bus.out_sum}, 32'h0045);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {13'd0, bus.out_sum, bus.out_valid, bus.out_cout, bus.out_ovf, bus.busy, bus.in_ready},
              32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
        check("post_reset_sum",     {16'd0, s},  32'h0000);
        check("post_reset_cout",    {31'd0, co}, 32'd1);
        check("post_reset_ovf",     {31'd0, ov}, 32'd0);
        check("post_reset_latency", lat,         32'd4);

        // ---- back-to-back stream, in_valid and out_ready held high ----
        begin
            logic [15:0] ra [3];
            logic [15:0] rb [3];
            logic        rc [3];
            logic        rs [3];
            int          acc_cyc [3];
            logic [17:0] exp;
            int          k, done_n, cyc;
            logic        accept, deliver;
            for (int i = 0; i < 3; i++) begin
                ra[i] = 16'($urandom);
                rb[i] = 16'($urandom);
                rc[i] = 1'($urandom_range(0, 1));
                rs[i] = 1'($urandom_range(0, 1));
            end
            k = 0; done_n = 0; cyc = 0;
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_a = ra[0]; bus.in_b = rb[0]; bus.in_cin = rc[0]; bus.in_sub = rs[0];
            bus.in_valid = 1'b1;
            while (done_n < 3 && cyc < 200) begin
                accept  = bus.in_valid && bus.in_ready;
                deliver = bus.out_valid && bus.out_ready;
                if (deliver) begin
                    exp = ref_model(ra[done_n], rb[done_n], rc[done_n], rs[done_n]);
                    check($sformatf("b2b%0d_sum", done_n),  {16'd0, bus.out_sum}, {16'd0, exp[15:0]});
                    check($sformatf("b2b%0d_cout", done_n), {31'd0, bus.out_cout}, {31'd0, exp[16]});
                    check($sformatf("b2b%0d_ovf", done_n),  {31'd0, bus.out_ovf},  {31'd0, exp[17]});
                    done_n++;
                end
                @(posedge clk);
                cyc++;
                if (accept && k < 3) begin
                    acc_cyc[k] = cyc;
                    k++;
                end
                @(negedge clk);
                if (k < 3) begin
                    bus.in_a = ra[k]; bus.in_b = rb[k]; bus.in_cin = rc[k]; bus.in_sub = rs[k];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            check("b2b_all_results", done_n, 32'd3);
            for (int i = 1; i < k; i++)
                check($sformatf("b2b_spacing%0d", i),
                      {31'd0, (acc_cyc[i] - acc_cyc[i-1]) >= 6}, 32'd1);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
